// File: rtl/glip_packet_tx_if.sv
// Flit-in / GLIP-word-out stream bundle for the device-to-host packetizer.
// The slave side is the packetizer; the master side is whoever feeds flits and drains words.
interface glip_packet_tx_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/glip_packet_tx.sv
// Store-and-forward GLIP packetizer: buffers one packet of flits, then emits
// its length word followed by the payload; packets longer than MAX_LEN are truncated.
module glip_packet_tx #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  glip_packet_tx_if.slave    bus,
  output logic               overflow
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_DROP = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [CW-1:0]    rd;
  logic [WIDTH-1:0] mem [MAX_LEN];

  logic in_hs;
  logic out_hs;
  logic last_word;

  assign bus.in_ready  = (state == S_FILL) || (state == S_DROP);
  assign bus.out_valid = (state == S_HDR) || (state == S_SEND);
  assign bus.out_data  = (state == S_HDR)  ? WIDTH'(count) :
                         (state == S_SEND) ? mem[rd[AW-1:0]] : '0;

  assign in_hs     = bus.in_valid & bus.in_ready;
  assign out_hs    = bus.out_valid & bus.out_ready;
  assign last_word = (rd == count - CW'(1));

  // Payload storage carries no reset; a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (!flush && state == S_FILL && in_hs)
      mem[count[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      count    <= '0;
      rd       <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      state    <= S_FILL;
      count    <= '0;
      rd       <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_hs) begin
            count <= count + CW'(1);
            if (bus.in_last) begin
              state <= S_HDR;
            end else if (count == LAST_IDX) begin
              overflow <= 1'b1;
              state    <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (in_hs && bus.in_last)
            state <= S_HDR;
        end
        S_HDR: begin
          if (out_hs) begin
            state <= S_SEND;
            rd    <= '0;
          end
        end
        S_SEND: begin
          if (out_hs) begin
            if (last_word) begin
              state <= S_FILL;
              count <= '0;
              rd    <= '0;
            end else begin
              rd <= rd + CW'(1);
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_glip_packet_tx.sv
// Directed bench for glip_packet_tx: framing, latency, backpressure, truncation,
// flush and back-to-back packets against hand-computed word sequences.
module tb_glip_packet_tx;

  logic clk;
  logic rst_n;
  logic flush;
  logic overflow;

  glip_packet_tx_if #(.WIDTH(16)) bus ();

  glip_packet_tx #(.WIDTH(16), .MAX_LEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;
  int cyc;
  logic [15:0] oq[$];
  int          ocyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Words are logged half a cycle before the edge that completes their handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      oq.push_back(bus.out_data);
      ocyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    oq.delete();
    ocyc.delete();
  endtask

  task automatic push_flit(input logic [15:0] d, input logic l);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 300) begin
          tests++;
          failed++;
          $display("FAIL push_timeout: in_ready stayed 0 for flit %h, required 1", d);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 400; k++) begin
      if (oq.size() >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    tests++;
    if (bus.out_data !== 16'h0000) begin failed++; $display("FAIL reset_out_data: got %h, required 0000", bus.out_data); end
    tests++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_three_flit();
    logic [15:0] exp_w [4];
    int last_cyc;
    exp_w = '{16'h0003, 16'h1111, 16'h2222, 16'h3333};
    clear_log();
    bus.out_ready = 1'b1;
    push_flit(16'h1111, 1'b0);
    push_flit(16'h2222, 1'b0);
    push_flit(16'h3333, 1'b1);
    last_cyc = cyc;
    wait_words(4);
    tests++;
    if (oq.size() != 4) begin failed++; $display("FAIL three_count: got %0d words, required 4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      tests++;
      if (oq[i] !== exp_w[i]) begin failed++; $display("FAIL three_word%0d: got %h, required %h", i, oq[i], exp_w[i]); end
      tests++;
      if (ocyc[i] != last_cyc + i) begin failed++; $display("FAIL three_timing%0d: got cycle %0d, required %0d", i, ocyc[i], last_cyc + i); end
    end
  endtask

  task automatic test_single();
    int low;
    clear_log();
    bus.out_ready = 1'b1;
    push_flit(16'hABCD, 1'b1);
    low = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.in_ready) low++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (low != 2) begin failed++; $display("FAIL single_ready_low: got %0d cycles, required 2", low); end
    tests++;
    if (oq.size() != 2) begin failed++; $display("FAIL single_count: got %0d words, required 2", oq.size()); end
    else begin
      tests++;
      if (oq[0] !== 16'h0001) begin failed++; $display("FAIL single_hdr: got %h, required 0001", oq[0]); end
      tests++;
      if (oq[1] !== 16'hABCD) begin failed++; $display("FAIL single_data: got %h, required abcd", oq[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w [5];
    logic [15:0] held;
    bit          stalled;
    exp_w = '{16'h0004, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    clear_log();
    bus.out_ready = 1'b0;
    push_flit(16'hA001, 1'b0);
    push_flit(16'hA002, 1'b0);
    push_flit(16'hA003, 1'b0);
    push_flit(16'hA004, 1'b1);
    stalled = 1'b0;
    held = '0;
    for (int k = 0; k < 40 && oq.size() < 5; k++) begin
      bus.out_ready = (k % 2 == 0);
      @(negedge clk);
      if (stalled) begin
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
          failed++;
          $display("FAIL bp_hold: got valid=%b data=%h, required valid=1 data=%h", bus.out_valid, bus.out_data, held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (oq.size() != 5) begin failed++; $display("FAIL bp_count: got %0d words, required 5", oq.size()); end
    for (int i = 0; i < 5 && i < oq.size(); i++) begin
      tests++;
      if (oq[i] !== exp_w[i]) begin failed++; $display("FAIL bp_word%0d: got %h, required %h", i, oq[i], exp_w[i]); end
    end
  endtask

  task automatic test_overflow();
    int bad;
    clear_log();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 70; i++)
      push_flit(16'h0100 + 16'(i), (i == 70));
    wait_words(65);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (oq.size() != 65) begin failed++; $display("FAIL ovf_count: got %0d words, required 65", oq.size()); end
    if (oq.size() >= 1) begin
      tests++;
      if (oq[0] !== 16'h0040) begin failed++; $display("FAIL ovf_hdr: got %h, required 0040", oq[0]); end
    end
    bad = 0;
    for (int i = 1; i < oq.size() && i <= 64; i++)
      if (oq[i] !== 16'h0100 + 16'(i)) bad++;
    tests++;
    if (bad != 0) begin failed++; $display("FAIL ovf_payload: got %0d wrong words, required 0", bad); end
    tests++;
    if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_flush();
    clear_log();
    bus.out_ready = 1'b1;
    push_flit(16'hC001, 1'b0);
    push_flit(16'hC002, 1'b0);
    push_flit(16'hC003, 1'b0);
    push_flit(16'hC004, 1'b1);
    for (int k = 0; k < 50 && oq.size() < 3; k++) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL flush_in_ready: got %b, required 1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL flush_out_valid: got %b, required 0", bus.out_valid); end
    tests++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL flush_overflow: got %b, required 0", overflow); end
    clear_log();
    bus.out_ready = 1'b1;
    push_flit(16'hD001, 1'b0);
    push_flit(16'hD002, 1'b1);
    wait_words(3);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (oq.size() != 3) begin failed++; $display("FAIL flush_next_count: got %0d words, required 3", oq.size()); end
    else begin
      tests++;
      if (oq[0] !== 16'h0002 || oq[1] !== 16'hD001 || oq[2] !== 16'hD002) begin
        failed++;
        $display("FAIL flush_next_words: got %h %h %h, required 0002 d001 d002", oq[0], oq[1], oq[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [9];
    exp_w = '{16'h0002, 16'hE001, 16'hE002,
              16'h0005, 16'hE101, 16'hE102, 16'hE103, 16'hE104, 16'hE105};
    clear_log();
    bus.out_ready = 1'b1;
    push_flit(16'hE001, 1'b0);
    push_flit(16'hE002, 1'b1);
    push_flit(16'hE101, 1'b0);
    push_flit(16'hE102, 1'b0);
    push_flit(16'hE103, 1'b0);
    push_flit(16'hE104, 1'b0);
    push_flit(16'hE105, 1'b1);
    wait_words(9);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (oq.size() != 9) begin failed++; $display("FAIL b2b_count: got %0d words, required 9", oq.size()); end
    for (int i = 0; i < 9 && i < oq.size(); i++) begin
      tests++;
      if (oq[i] !== exp_w[i]) begin failed++; $display("FAIL b2b_word%0d: got %h, required %h", i, oq[i], exp_w[i]); end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    test_reset();
    test_three_flit();
    test_single();
    test_backpressure();
    test_overflow();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
